// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: memory funct3 encodings, FSM states
// and the request fault classifiers used at accept time.
package load_store_unit_pkg;

  typedef enum logic [2:0] {
    BYTE   = 3'b000,
    HALF   = 3'b001,
    WORD   = 3'b010,
    BYTE_U = 3'b100,
    HALF_U = 3'b101
  } funct3_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } lsu_state_t;

  function automatic logic is_misaligned(funct3_t f3, logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (f3)
      HALF, HALF_U: mis = addr_lo[0];
      WORD:         mis = (addr_lo != 2'b00);
      default:      mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Unsigned variants only make sense for loads; unlisted encodings are never legal.
  function automatic logic is_illegal(funct3_t f3, logic we);
    logic ill;
    ill = 1'b1;
    case (f3)
      BYTE, HALF, WORD: ill = 1'b0;
      BYTE_U, HALF_U:   ill = we;
      default:          ill = 1'b1;
    endcase
    return ill;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core-side request/response bundle between the execute stage and the LSU.
interface load_store_unit_if
  import load_store_unit_pkg::*;
#(
  parameter int WIDTH = 32
);
  // A request transfers on a rising edge where req_valid && req_ready; the
  // master holds req_* stable while req_valid is high and unaccepted.
  // resp_valid is a single-cycle pulse with no backpressure.
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [WIDTH-1:0] req_addr;
  logic [WIDTH-1:0] req_wdata;
  funct3_t          req_funct3;
  logic             resp_valid;
  logic [WIDTH-1:0] resp_rdata;
  logic             resp_misaligned;
  logic             resp_illegal;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_funct3,
    input  req_ready, resp_valid, resp_rdata, resp_misaligned, resp_illegal
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_funct3,
    output req_ready, resp_valid, resp_rdata, resp_misaligned, resp_illegal
  );
endinterface

// File: rtl/load_store_unit_load_extend.sv
// Sign/zero extension of right-justified load data according to funct3.
module lsu_load_extend
  import load_store_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  funct3_t          funct3_i,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] ext_o
);
  always_comb begin
    ext_o = raw_i;
    case (funct3_i)
      BYTE:    ext_o = {{(WIDTH-8){raw_i[7]}}, raw_i[7:0]};
      HALF:    ext_o = {{(WIDTH-16){raw_i[15]}}, raw_i[15:0]};
      BYTE_U:  ext_o = {{(WIDTH-8){1'b0}}, raw_i[7:0]};
      HALF_U:  ext_o = {{(WIDTH-16){1'b0}}, raw_i[15:0]};
      default: ext_o = raw_i;
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// Core-side initiator for the data memory: accepts one load/store, checks
// faults, drives the memory port, waits the read latency and returns a response.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  load_store_unit_if.slave core,
  output logic [WIDTH-1:0] mem_addr,
  output logic             mem_wren,
  output logic [WIDTH-1:0] mem_wr_data,
  output funct3_t          mem_funct3,
  input  logic [WIDTH-1:0] mem_rd_data,
  output lsu_state_t       dbg_state
);
  localparam int CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  lsu_state_t       state_q;
  logic             req_ready_q;
  logic             resp_valid_q, resp_mis_q, resp_ill_q;
  logic [WIDTH-1:0] resp_rdata_q;
  logic [WIDTH-1:0] mem_addr_q, mem_wr_data_q;
  logic             mem_wren_q;
  funct3_t          mem_funct3_q;
  logic             we_q;
  logic [CNT_W-1:0] cnt_q;

  logic             mis_d, ill_d;
  logic [WIDTH-1:0] wdata_d, ext_data;

  assign mis_d = is_misaligned(core.req_funct3, core.req_addr[1:0]);
  assign ill_d = is_illegal(core.req_funct3, core.req_we);

  always_comb begin
    wdata_d = core.req_wdata;
    case (core.req_funct3)
      BYTE, BYTE_U: wdata_d = {{(WIDTH-8){1'b0}}, core.req_wdata[7:0]};
      HALF, HALF_U: wdata_d = {{(WIDTH-16){1'b0}}, core.req_wdata[15:0]};
      default:      wdata_d = core.req_wdata;
    endcase
  end

  // mem_funct3_q is only rewritten on an issued access, so it still describes the load in WAIT.
  lsu_load_extend #(.WIDTH(WIDTH)) u_ext (
    .funct3_i(mem_funct3_q),
    .raw_i   (mem_rd_data),
    .ext_o   (ext_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      req_ready_q   <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_mis_q    <= 1'b0;
      resp_ill_q    <= 1'b0;
      resp_rdata_q  <= '0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
      mem_wren_q    <= 1'b0;
      mem_funct3_q  <= BYTE;
      we_q          <= 1'b0;
      cnt_q         <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      mem_wren_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          req_ready_q <= 1'b1;
          if (req_ready_q && core.req_valid) begin
            req_ready_q <= 1'b0;
            we_q        <= core.req_we;
            if (mis_d || ill_d) begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_rdata_q <= '0;
              resp_mis_q   <= mis_d;
              resp_ill_q   <= ill_d;
            end else begin
              state_q      <= S_ISSUE;
              mem_addr_q   <= core.req_addr;
              mem_funct3_q <= core.req_funct3;
              mem_wren_q   <= core.req_we;
              if (core.req_we) mem_wr_data_q <= wdata_d;
            end
          end
        end
        S_ISSUE: begin
          if (we_q) begin
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= '0;
            resp_mis_q   <= 1'b0;
            resp_ill_q   <= 1'b0;
          end else begin
            state_q <= S_WAIT;
            cnt_q   <= CNT_W'(RD_LATENCY - 1);
          end
        end
        S_WAIT: begin
          if (cnt_q == '0) begin
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= ext_data;
            resp_mis_q   <= 1'b0;
            resp_ill_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_RESP: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign core.req_ready       = req_ready_q;
  assign core.resp_valid      = resp_valid_q;
  assign core.resp_rdata      = resp_rdata_q;
  assign core.resp_misaligned = resp_mis_q;
  assign core.resp_illegal    = resp_ill_q;
  assign mem_addr             = mem_addr_q;
  assign mem_wren             = mem_wren_q;
  assign mem_wr_data          = mem_wr_data_q;
  assign mem_funct3           = mem_funct3_q;
  assign dbg_state            = state_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: behavioural byte memory with a flash preload port,
// reference model feeding an expected queue, and a monitor comparing responses.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  localparam int W         = 32;
  localparam int RL        = 2;
  localparam int MEM_BYTES = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  load_store_unit_if #(.WIDTH(W)) bus ();
  logic [W-1:0] mem_addr, mem_wr_data, mem_rd_data;
  logic         mem_wren;
  funct3_t      mem_funct3;
  lsu_state_t   dbg_state;

  load_store_unit #(.WIDTH(W), .RD_LATENCY(RL)) dut (
    .clk        (clk),
    .rst        (rst),
    .core       (bus),
    .mem_addr   (mem_addr),
    .mem_wren   (mem_wren),
    .mem_wr_data(mem_wr_data),
    .mem_funct3 (mem_funct3),
    .mem_rd_data(mem_rd_data),
    .dbg_state  (dbg_state)
  );

  // ---------------- memory responder ----------------
  logic [7:0]  mem_bytes [MEM_BYTES];
  logic [W-1:0] rd_pipe  [RL];
  logic        flash_we   = 1'b0;
  logic [5:0]  flash_addr = '0;
  logic [31:0] flash_data = '0;

  function automatic logic [31:0] mem_word(input logic [5:0] a);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = mem_bytes[6'(a + 6'(i))];
    return w;
  endfunction

  function automatic int size_bytes(input logic [2:0] f3);
    if (f3[1:0] == 2'd0) return 1;
    if (f3[1:0] == 2'd1) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] mem_read(input logic [5:0] a, input logic [2:0] f3);
    logic [31:0] w;
    w = mem_word(a);
    case (size_bytes(f3))
      1:       return w & 32'h0000_00FF;
      2:       return w & 32'h0000_FFFF;
      default: return w;
    endcase
  endfunction

  always @(posedge clk) begin
    if (flash_we)
      for (int i = 0; i < 4; i++) mem_bytes[6'(flash_addr + 6'(i))] <= flash_data[8*i +: 8];
    if (mem_wren)
      for (int i = 0; i < 4; i++)
        if (i < size_bytes(mem_funct3)) mem_bytes[6'(mem_addr[5:0] + 6'(i))] <= mem_wr_data[8*i +: 8];
    rd_pipe[0] <= mem_read(mem_addr[5:0], mem_funct3);
    for (int s = 1; s < RL; s++) rd_pipe[s] <= rd_pipe[s-1];
  end
  assign mem_rd_data = rd_pipe[RL-1];

  // ---------------- reference model + scoreboard ----------------
  logic [7:0]   ref_mem [MEM_BYTES];
  logic [W-1:0] exp_q[$];
  logic [1:0]   exp_flags_q[$];
  int           exp_lat_q[$];
  int           exp_acc_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int wren_cycles = 0;
  int exp_stores = 0;
  int prev_acc = 0;
  int prev_gap = 0;
  bit prev_hold = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Latency is counted from the accept edge to the first negedge showing resp_valid.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output logic [31:0] rd, output logic mis,
                       output logic ill, output int lat);
    int a, sz;
    logic [31:0] raw;
    a   = int'(addr % 64);
    sz  = size_bytes(f3);
    mis = ((f3 == 3'd1 || f3 == 3'd5) && (addr % 2 != 0)) || (f3 == 3'd2 && (addr % 4 != 0));
    ill = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) || (we && (f3 == 3'd4 || f3 == 3'd5));
    rd  = '0;
    if (mis || ill) begin
      lat = 0;
    end else if (we) begin
      lat = 1;
      for (int i = 0; i < sz; i++) ref_mem[(a + i) % 64] = wd[8*i +: 8];
      exp_stores++;
    end else begin
      lat = 1 + RL;
      raw = '0;
      for (int i = 0; i < sz; i++) raw[8*i +: 8] = ref_mem[(a + i) % 64];
      case (f3)
        3'd0:    rd = 32'($signed(raw[7:0]));
        3'd1:    rd = 32'($signed(raw[15:0]));
        default: rd = raw;
      endcase
    end
  endtask

  // ---------------- driver ----------------
  task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, input bit hold, input bit track);
    int n;
    logic [31:0] rd;
    logic mis, ill;
    int lat;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = funct3_t'(f3);
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    n = 0;
    while (!bus.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: req_ready stayed 0 for %0d cycles", n);
      bus.req_valid = 1'b0;
      prev_hold = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (track) begin
      model(we, f3, addr, wd, rd, mis, ill, lat);
      exp_q.push_back(rd);
      exp_flags_q.push_back({mis, ill});
      exp_lat_q.push_back(lat);
      exp_acc_q.push_back(cyc);
      if (prev_hold) chk("accept_gap", 32'(cyc - prev_acc), 32'(prev_gap));
      prev_acc  = cyc;
      prev_gap  = lat + 2;
      prev_hold = hold;
    end else begin
      prev_hold = 1'b0;
    end
    if (!hold) bus.req_valid = 1'b0;
    // Scramble the request fields; the accepted transaction must not notice.
    bus.req_we     = 1'($urandom);
    bus.req_funct3 = funct3_t'(3'($urandom));
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;
  endtask

  // ---------------- monitor ----------------
  logic [31:0] m_rd;
  logic [1:0]  m_fl;
  int          m_lat, m_acc;

  always @(negedge clk) begin
    if (mem_wren) wren_cycles++;
    if (bus.resp_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_resp: resp_valid with nothing outstanding (cycle %0d)", cyc);
      end else begin
        m_rd  = exp_q.pop_front();
        m_fl  = exp_flags_q.pop_front();
        m_lat = exp_lat_q.pop_front();
        m_acc = exp_acc_q.pop_front();
        chk("resp_rdata", bus.resp_rdata, m_rd);
        chk("resp_misaligned", 32'(bus.resp_misaligned), 32'(m_fl[1]));
        chk("resp_illegal", 32'(bus.resp_illegal), 32'(m_fl[0]));
        chk("resp_latency", 32'(cyc - m_acc), 32'(m_lat));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] w;
    logic [2:0]  f3;
    logic [31:0] a;
    int          n;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = BYTE;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;

    // Preload through the flash port while reset is held.
    for (int k = 0; k < MEM_BYTES / 4; k++) begin
      @(negedge clk);
      w = (k == 0) ? 32'h0000_00F0 : $urandom;
      flash_we   = 1'b1;
      flash_addr = 6'(k * 4);
      flash_data = w;
      for (int i = 0; i < 4; i++) ref_mem[k*4 + i] = w[8*i +: 8];
    end
    @(negedge clk);
    flash_we = 1'b0;

    chk("reset_req_ready", 32'(bus.req_ready), 32'd0);
    chk("reset_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("reset_mem_wren", 32'(mem_wren), 32'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    chk("reset_state", 32'(dbg_state), 32'(S_IDLE));

    rst = 1'b0;
    chk("ready_low_at_release", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    chk("ready_after_release", 32'(bus.req_ready), 32'd1);

    // Directed cases
    send(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1);           // BYTE  -> 0xFFFFFFF0
    send(1'b0, 3'd4, 32'd0, 32'd0, 1'b0, 1'b1);           // BYTE_U -> 0xF0
    send(1'b1, 3'd2, 32'd8, 32'd101010, 1'b0, 1'b1);
    send(1'b0, 3'd2, 32'd8, 32'd0, 1'b0, 1'b1);
    send(1'b0, 3'd1, 32'd3, 32'd0, 1'b0, 1'b1);           // misaligned
    send(1'b1, 3'd4, 32'd8, 32'hDEAD_BEEF, 1'b0, 1'b1);   // illegal store
    send(1'b0, 3'd2, 32'd8, 32'd0, 1'b0, 1'b1);
    send(1'b1, 3'd5, 32'd3, 32'd0, 1'b0, 1'b1);           // both flags

    // Reset while a load sits in WAIT
    send(1'b0, 3'd2, 32'd8, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("state_wait", 32'(dbg_state), 32'(S_WAIT));
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_mem_wren", 32'(mem_wren), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_abort", 32'(bus.req_ready), 32'd1);
    send(1'b0, 3'd2, 32'd8, 32'd0, 1'b0, 1'b1);

    // Back-to-back with req_valid held high
    for (int i = 0; i < 8; i++) begin
      f3 = 3'(i % 3);
      send(1'(i % 2), f3, 32'(4 * i + (i == 5 ? 1 : 0)), $urandom, (i < 7), 1'b1);
    end

    // Randomised traffic
    for (int i = 0; i < 150; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = 32'($urandom_range(0, 60));
      if ($urandom_range(0, 1) == 1) a = a & ~32'd3;
      send(1'($urandom_range(0, 1)), f3, a, $urandom,
           (i < 149) && ($urandom_range(0, 2) == 0), 1'b1);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d responses outstanding", exp_q.size());
    end
    repeat (3) @(negedge clk);

    chk("store_pulse_count", 32'(wren_cycles), 32'(exp_stores));
    for (int k = 0; k < MEM_BYTES / 4; k++) begin
      for (int i = 0; i < 4; i++) w[8*i +: 8] = ref_mem[k*4 + i];
      chk("final_mem_word", mem_word(6'(k * 4)), w);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Core-side initiator for the data `memory` port: accepts one load or store per handshake from the execute stage and drives the memory's `addr`/`wren`/`wr_data`/`funct3` inputs. It also checks alignment and funct3 legality, waits the memory's read latency, and returns a sign- or zero-extended load result. It sits between the datapath and `memory`, which remains the responder; the flash port is untouched.

## Interface
- `WIDTH`, 32, data/address width
- `RD_LATENCY`, 1, cycles from `mem_addr` valid (with `mem_wren`=0) to `mem_rd_data` valid; must be ≥1
- `clk` in 1 — clock, all logic on rising edge
- `rst` in 1 — synchronous, active-high reset
- `req_valid` in 1 — core request present
- `req_ready` out 1 — unit can accept; high only in IDLE
- `req_we` in 1 — 1 store, 0 load
- `req_addr` in WIDTH — byte address
- `req_wdata` in WIDTH — store data, right-justified
- `req_funct3` in funct3_t — access size/signedness
- `resp_valid` out 1 — one-cycle completion pulse; no backpressure
- `resp_rdata` out WIDTH — extended load data; 0 for stores/faults
- `resp_misaligned` out 1 — qualified by `resp_valid`
- `resp_illegal` out 1 — qualified by `resp_valid`
- `mem_addr` out WIDTH — to memory `addr`
- `mem_wren` out 1 — to memory `wren`
- `mem_wr_data` out WIDTH — to memory `wr_data`
- `mem_funct3` out funct3_t — to memory `funct3`
- `mem_rd_data` in WIDTH — from memory `rd_data`, right-justified, size-truncated by memory

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: `req_ready`=1. On `req_valid` at an edge, latch request; go to RESP on fault, else ISSUE.
- Faults (no memory access, `mem_wren` stays 0): misaligned = HALF/HALF_U with addr[0]=1, WORD with addr[1:0]≠0. Illegal = funct3 011/110/111, or store with BYTE_U/HALF_U. Misaligned and illegal are reported independently; both may be set.
- ISSUE (one cycle): drive `mem_addr`, `mem_funct3`. Store: `mem_wren`=1, `mem_wr_data` = `req_wdata` masked to size (upper bits 0); then RESP. Load: `mem_wren`=0; then WAIT.
- WAIT: counter loads RD_LATENCY−1 on entry to WAIT, decrements each cycle; in the cycle it reads 0, capture `mem_rd_data`, extend, go RESP. RD_LATENCY=1 means one WAIT cycle.
- Extension: BYTE sign-extends bit 7, HALF bit 15, BYTE_U/HALF_U zero-extend, WORD passes through.
- RESP (one cycle): `resp_valid`=1 with data/flags; then IDLE.
- `mem_addr`, `mem_funct3`, `mem_wr_data` are registered and hold their last value outside ISSUE/WAIT; `mem_wren` is 1 only in ISSUE of a store.

## Timing
- Accept at edge k (IDLE, `req_valid`=1). Store: `mem_wren`=1 cycle k+1, `resp_valid` cycle k+2, `req_ready` cycle k+3. Load: issue k+1, WAIT k+2..k+1+RD_LATENCY, `resp_valid` k+2+RD_LATENCY. Fault: `resp_valid` k+1.
- Throughput: a store takes 3 cycles from accept to the next accept; a load takes 3+RD_LATENCY.
- `req_*` sampled only at accept; changes afterwards are ignored.
- Reset values: state IDLE; `req_ready`, `resp_*`, `mem_*` outputs all 0. `req_ready` rises the cycle after `rst` deasserts.
- `rst` mid-operation: abort at that edge, no `resp_valid`, `mem_wren` low from that edge.

## Structure
- Extend `LOAD_STORE_FNS` with `funct3_t` encodings BYTE=000, HALF=001, WORD=010, BYTE_U=100, HALF_U=101 (add any missing), plus the `lsu_state_t` enum.
- One combinational sub-module `lsu_load_extend` (funct3, raw data → extended data); the FSM, counter and fault checks live in `load_store_unit`.
- Bench instantiates `load_store_unit` driving a real `memory` instance, preloaded through the flash port.

## Test plan
- Flash 0x000000F0 at addr 0; load BYTE addr 0 → `resp_rdata`=0xFFFFFFF0; BYTE_U → 0x000000F0; `resp_valid` at k+2+RD_LATENCY.
- Store WORD 101010 to addr 8 (`mem_wren` high exactly one cycle), then load WORD addr 8 → 101010.
- Load HALF addr 3 → `resp_valid` at k+1, `resp_misaligned`=1, `mem_wren` never asserted, `resp_rdata`=0.
- Store with funct3=BYTE_U → `resp_illegal`=1 at k+1, memory unchanged (reread shows old value).
- Assert `rst` during WAIT → no `resp_valid`; `req_ready`=0 during reset, 1 the cycle after release; next load returns correct data.
- Back-to-back requests with `req_valid` held high → each accepted only in IDLE, responses in order, none dropped.
